// File: rtl/serial_add_pkg.sv
// Shared types and constants for the serial multi-byte adder.
package serial_add_pkg;

   localparam int unsigned BYTE_W = 8;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/byte_add_c.sv
// Combinational byte adder: {co, s} = a + b + ci.
module byte_add_c
   import serial_add_pkg::*;
(
   input  logic [BYTE_W-1:0] a,
   input  logic [BYTE_W-1:0] b,
   input  logic              ci,
   output logic              co,
   output logic [BYTE_W-1:0] s
);

   // Nine-bit sum, top bit is the carry out
   always_comb begin
      {co, s} = (BYTE_W+1)'(a) + (BYTE_W+1)'(b) + (BYTE_W+1)'(ci);
   end

endmodule

// File: rtl/serial_add_seq.sv
// Serial LSB-first multi-byte adder with one-cycle registered output,
// valid/ready handshakes and a sticky protocol-error flag.
// Optional feature macro OVF_COUNT_EN adds the 16-bit ovf_count output
// (operations that finished with a carry out).
module serial_add_seq
   import serial_add_pkg::*;
#(
   parameter int unsigned MAX_BYTES = 16
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [BYTE_W-1:0] in_a,
   input  logic [BYTE_W-1:0] in_b,
   input  logic              in_first,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [BYTE_W-1:0] out_sum,
   output logic              out_last,
   output logic              out_carry,
   output logic              err
`ifdef OVF_COUNT_EN
   ,
   output logic [15:0]       ovf_count
`endif
);

   localparam int unsigned CNT_W = 8;

   state_t             state_q, state_d;
   logic               carry_q, carry_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               out_valid_q, out_valid_d;
   logic [BYTE_W-1:0]  sum_q, sum_d;
   logic               last_q, last_d;
   logic               ocarry_q, ocarry_d;
   logic               err_q, err_d;
`ifdef OVF_COUNT_EN
   logic [15:0]        ovf_q, ovf_d;
`endif

   logic               xfer;
   logic               start;
   logic               proto_err;
   logic               add_ci;
   logic               add_co;
   logic [BYTE_W-1:0]  add_s;
   logic [CNT_W-1:0]   cnt_next;
   logic               force_end;

   // Handshake and operation-boundary decode
   assign in_ready  = !out_valid_q || out_ready;
   assign xfer      = in_valid && in_ready;
   // A byte in IDLE always starts fresh; a first byte in RUN restarts the operation
   assign start     = (state_q == IDLE) || in_first;
   assign proto_err = ((state_q == IDLE) && !in_first) || ((state_q == RUN) && in_first);
   assign add_ci    = start ? 1'b0 : carry_q;
   assign cnt_next  = start ? CNT_W'(1) : cnt_q + CNT_W'(1);
   assign force_end = !in_last && (cnt_next == CNT_W'(MAX_BYTES));

   byte_add_c u_add (
      .a  (in_a),
      .b  (in_b),
      .ci (add_ci),
      .co (add_co),
      .s  (add_s)
   );

   // Next-state and output-register update
   always_comb begin
      state_d     = state_q;
      carry_d     = carry_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      sum_d       = sum_q;
      last_d      = last_q;
      ocarry_d    = ocarry_q;
      err_d       = err_q;
`ifdef OVF_COUNT_EN
      ovf_d       = ovf_q;
`endif
      if (out_ready) begin
         out_valid_d = 1'b0;
      end
      if (xfer) begin
         out_valid_d = 1'b1;
         sum_d       = add_s;
         last_d      = in_last || force_end;
         ocarry_d    = add_co;
         carry_d     = add_co;
         cnt_d       = cnt_next;
         state_d     = (in_last || force_end) ? IDLE : RUN;
         if (proto_err || force_end) begin
            err_d = 1'b1;
         end
`ifdef OVF_COUNT_EN
         if ((in_last || force_end) && add_co) begin
            ovf_d = ovf_q + 16'd1;
         end
`endif
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         carry_q     <= 1'b0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         last_q      <= 1'b0;
         ocarry_q    <= 1'b0;
         err_q       <= 1'b0;
`ifdef OVF_COUNT_EN
         ovf_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         carry_q     <= carry_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         sum_q       <= sum_d;
         last_q      <= last_d;
         ocarry_q    <= ocarry_d;
         err_q       <= err_d;
`ifdef OVF_COUNT_EN
         ovf_q       <= ovf_d;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign out_sum   = sum_q;
   assign out_last  = last_q;
   assign out_carry = ocarry_q;
   assign err       = err_q;
`ifdef OVF_COUNT_EN
   assign ovf_count = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_seq.sv
// Self-checking bench for serial_add_seq: directed protocol cases plus
// randomized multi-byte additions checked against whole-operand arithmetic.
module tb_serial_add_seq;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_a;
   logic [7:0] in_b;
   logic       in_first;
   logic       in_last;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_sum;
   logic       out_last;
   logic       out_carry;
   logic       err;

   logic       in_ready2;
   logic       out_valid2;
   logic [7:0] out_sum2;
   logic       out_last2;
   logic       out_carry2;
   logic       err2;

`ifdef OVF_COUNT_EN
   logic [15:0] ovf_count;
   logic [15:0] ovf_count2;
`endif

   int checks   = 0;
   int failures = 0;

   serial_add_seq #(.MAX_BYTES(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_first  (in_first),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_last  (out_last),
      .out_carry (out_carry),
      .err       (err)
`ifdef OVF_COUNT_EN
      ,
      .ovf_count (ovf_count)
`endif
   );

   // Second instance with the smallest legal operand length
   serial_add_seq #(.MAX_BYTES(2)) dut2 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready2),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_first  (in_first),
      .in_last   (in_last),
      .out_valid (out_valid2),
      .out_ready (out_ready),
      .out_sum   (out_sum2),
      .out_last  (out_last2),
      .out_carry (out_carry2),
      .err       (err2)
`ifdef OVF_COUNT_EN
      ,
      .ovf_count (ovf_count2)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       first;
      logic       last;
   } in_t;

   typedef struct {
      logic [7:0] s;
      logic       last;
      logic       carry;
   } out_t;

   in_t  stim_q[$];
   out_t exp_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Present one byte pair with the consumer ready; returns #1 after the accepting edge
   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic f, input logic l);
      in_a      = a;
      in_b      = b;
      in_first  = f;
      in_last   = l;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      logic [63:0] opa, opb;
      logic [64:0] full;
      int          len;
      int          guard;
      bit          fire_in;
      int          exp_ovf;
      out_t        e;
      in_t         st;

      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_a = '0; in_b = '0; in_first = 1'b0; in_last = 1'b0;

      // Reset state
      @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_sum",   32'(out_sum),   32'd0);
      chk("rst_out_last",  32'(out_last),  32'd0);
      chk("rst_out_carry", 32'(out_carry), 32'd0);
      chk("rst_err",       32'(err),       32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd1);
`ifdef OVF_COUNT_EN
      chk("rst_ovf",       32'(ovf_count), 32'd0);
`endif
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Single byte
      send(8'h12, 8'h34, 1'b1, 1'b1);
      chk("single_valid", 32'(out_valid), 32'd1);
      chk("single_sum",   32'(out_sum),   32'h46);
      chk("single_last",  32'(out_last),  32'd1);
      chk("single_carry", 32'(out_carry), 32'd0);
      @(posedge clk);
      #1;
      chk("single_valid_clear", 32'(out_valid), 32'd0);

      // Single-byte overflow
      send(8'hFF, 8'h01, 1'b1, 1'b1);
      chk("ovf_sum",   32'(out_sum),   32'h00);
      chk("ovf_last",  32'(out_last),  32'd1);
      chk("ovf_carry", 32'(out_carry), 32'd1);
`ifdef OVF_COUNT_EN
      chk("ovf_count1", 32'(ovf_count), 32'd1);
`endif

      // Two-byte 0x01FF + 0x0001
      send(8'hFF, 8'h01, 1'b1, 1'b0);
      chk("two_b0_sum",  32'(out_sum),  32'h00);
      chk("two_b0_last", 32'(out_last), 32'd0);
      send(8'h01, 8'h00, 1'b0, 1'b1);
      chk("two_b1_sum",   32'(out_sum),   32'h02);
      chk("two_b1_last",  32'(out_last),  32'd1);
      chk("two_b1_carry", 32'(out_carry), 32'd0);
      chk("two_err",      32'(err),       32'd0);

      // Backpressure: consumer stalls with the next byte waiting
      send(8'hFF, 8'h01, 1'b1, 1'b0);
      out_ready = 1'b0;
      in_a = 8'h01; in_b = 8'h00; in_first = 1'b0; in_last = 1'b1;
      in_valid  = 1'b1;
      #1;
      chk("bp_in_ready0", 32'(in_ready), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("bp_in_ready", 32'(in_ready),  32'd0);
         chk("bp_hold_sum", 32'(out_sum),   32'h00);
         chk("bp_hold_vld", 32'(out_valid), 32'd1);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("bp_after_sum",   32'(out_sum),   32'h02);
      chk("bp_after_last",  32'(out_last),  32'd1);
      chk("bp_after_carry", 32'(out_carry), 32'd0);
      @(posedge clk);
      #1;

      // First byte arriving mid-operation restarts with no carry in
      send(8'hFF, 8'h01, 1'b1, 1'b0);
      send(8'h05, 8'h06, 1'b1, 1'b0);
      chk("restart_sum", 32'(out_sum), 32'h0B);
      chk("restart_err", 32'(err),     32'd1);
      send(8'h01, 8'h01, 1'b0, 1'b1);
      chk("restart_tail_sum", 32'(out_sum), 32'h02);
      chk("err_sticky",       32'(err),     32'd1);
      do_reset();
      chk("err_cleared", 32'(err), 32'd0);

      // Length limit on the MAX_BYTES=2 instance
      send(8'h10, 8'h20, 1'b1, 1'b0);
      chk("max_b0_sum",  32'(out_sum2),  32'h30);
      chk("max_b0_last", 32'(out_last2), 32'd0);
      send(8'h30, 8'h40, 1'b0, 1'b0);
      chk("max_b1_sum",  32'(out_sum2),  32'h70);
      chk("max_b1_last", 32'(out_last2), 32'd1);
      chk("max_b1_err",  32'(err2),      32'd1);
      chk("max16_last",  32'(out_last),  32'd0);
      chk("max16_err",   32'(err),       32'd0);
      send(8'h01, 8'h02, 1'b0, 1'b0);
      chk("max_b2_sum",  32'(out_sum2),  32'h03);
      chk("max_b2_last", 32'(out_last2), 32'd0);
      do_reset();

      // Reset mid-operation discards partial state and pending output
      send(8'hFF, 8'h01, 1'b1, 1'b0);
      rst = 1'b0;
      #1;
      chk("mrst_valid", 32'(out_valid), 32'd0);
      chk("mrst_sum",   32'(out_sum),   32'd0);
      chk("mrst_last",  32'(out_last),  32'd0);
      chk("mrst_carry", 32'(out_carry), 32'd0);
      chk("mrst_ready", 32'(in_ready),  32'd1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      send(8'h01, 8'h01, 1'b0, 1'b1);
      chk("mrst_next_sum", 32'(out_sum), 32'h02);
      chk("mrst_next_err", 32'(err),     32'd1);
      do_reset();

      // Random legal operations of 1..8 bytes under random flow control
      exp_ovf = 0;
      for (int n = 0; n < 40; n++) begin
         len = $urandom_range(1, 8);
         opa = {$urandom, $urandom};
         opb = {$urandom, $urandom};
         if (len < 8) begin
            opa = opa & ((64'd1 << (8 * len)) - 64'd1);
            opb = opb & ((64'd1 << (8 * len)) - 64'd1);
         end
         full = {1'b0, opa} + {1'b0, opb};
         for (int i = 0; i < len; i++) begin
            st.a = opa[8*i +: 8];
            st.b = opb[8*i +: 8];
            st.first = (i == 0);
            st.last  = (i == len - 1);
            stim_q.push_back(st);
            e.s     = full[8*i +: 8];
            e.last  = (i == len - 1);
            e.carry = (i == len - 1) ? full[8*len] : 1'b0;
            exp_q.push_back(e);
         end
         if (full[8*len]) exp_ovf++;
      end

      guard   = 0;
      in_valid = 1'b0;
      while ((stim_q.size() > 0 || exp_q.size() > 0) && guard < 20000) begin
         guard++;
         out_ready = ($urandom_range(0, 3) != 0);
         if (!in_valid && stim_q.size() > 0 && $urandom_range(0, 3) != 0) begin
            in_a     = stim_q[0].a;
            in_b     = stim_q[0].b;
            in_first = stim_q[0].first;
            in_last  = stim_q[0].last;
            in_valid = 1'b1;
         end
         #1;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("rnd_spurious_out", 32'(out_valid), 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("rnd_sum",  32'(out_sum),  32'(e.s));
               chk("rnd_last", 32'(out_last), 32'(e.last));
               if (e.last) chk("rnd_carry", 32'(out_carry), 32'(e.carry));
            end
         end
         fire_in = in_valid && in_ready;
         @(posedge clk);
         #1;
         if (fire_in) begin
            void'(stim_q.pop_front());
            in_valid = 1'b0;
         end
      end
      if (guard >= 20000) begin
         chk("rnd_timeout", 32'(stim_q.size() + exp_q.size()), 32'd0);
      end
      chk("rnd_err", 32'(err), 32'd0);
`ifdef OVF_COUNT_EN
      chk("rnd_ovf_count", 32'(ovf_count), 32'(exp_ovf));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
